// File: rtl/cordic_pkg.sv
// cordic_pkg: shared select indices, Q7.8 limits, FSM states and saturating negate for the result unit
package cordic_pkg;
  localparam int FRAC = 8;
  localparam int SEL_SIN = 0;
  localparam int SEL_COS = 1;
  localparam int SEL_TAN = 2;
  localparam int SEL_ATAN = 3;
  localparam logic [15:0] Q_MAX = 16'h7FFF;
  localparam logic [15:0] Q_MIN_SAT = 16'h8001;
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FMT, S_HOLD} state_t;
  function automatic logic [15:0] sat_neg(input logic [15:0] v);
    return (v == 16'h8000) ? Q_MAX : 16'(-v);
  endfunction
endpackage

// File: rtl/cordic_result_unit_if.sv
// cordic_result_unit_if: core capture inputs plus result valid/ready handshake; master drives core_valid/x_in/y_in/angle_in/infor/select/out_ready, slave drives out_valid/out_data/err/busy/overrun
interface cordic_result_unit_if #(parameter int W = 16);
  logic core_valid;
  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [W-1:0] angle_in;
  logic [1:0] infor;
  logic [3:0] select;
  logic out_ready;
  logic out_valid;
  logic [W-1:0] out_data;
  logic err;
  logic busy;
  logic overrun;
  modport master(output core_valid, x_in, y_in, angle_in, infor, select, out_ready, input out_valid, out_data, err, busy, overrun);
  modport slave(input core_valid, x_in, y_in, angle_in, infor, select, out_ready, output out_valid, out_data, err, busy, overrun);
endinterface

// File: rtl/cordic_seq_div.sv
// cordic_seq_div: 16-cycle unsigned restoring divider, one quotient bit per cycle MSB first; ports clk, rst, start, dividend[23:0], divisor[15:0], done, quotient[15:0]
module cordic_seq_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] dividend,
  input  logic [15:0] divisor,
  output logic        done,
  output logic [15:0] quotient
);
  logic [4:0] cnt;
  logic [15:0] rem;
  logic [15:0] dq;
  logic [16:0] t;
  logic ge;
  always_comb begin
    t = {rem, dq[15]};
    ge = t >= {1'b0, divisor};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      rem <= '0;
      dq <= '0;
    end else if (start) begin
      cnt <= 5'd16;
      rem <= {8'b0, dividend[23:16]};
      dq <= dividend[15:0];
    end else if (cnt != 0) begin
      cnt <= cnt - 5'd1;
      rem <= ge ? 16'(t - {1'b0, divisor}) : t[15:0];
      dq <= {dq[14:0], ge};
    end
  end
  assign done = cnt == 5'd1;
  assign quotient = dq;
endmodule

// File: rtl/cordic_result_unit.sv
// cordic_result_unit: quadrant-corrects core vectors and returns sin/cos/tan/atan in Q7.8 behind valid/ready; ports clk, rst, bus (cordic_result_unit_if.slave)
module cordic_result_unit import cordic_pkg::*; #(
  parameter int W = 16,
  parameter int FRAC = 8
) (
  input logic clk,
  input logic rst,
  cordic_result_unit_if.slave bus
);
  state_t state;
  logic [W-1:0] xc, yc, ax, ay, sel_data, q, data_p;
  logic onehot, is_tan, tan_neg, tan_sat, accept, capture, div_done, err_p, tan_r, neg_r;
  always_comb begin
    xc = bus.infor[0] ? sat_neg(bus.x_in) : bus.x_in;
    yc = bus.infor[1] ? sat_neg(bus.y_in) : bus.y_in;
    ax = xc[W-1] ? W'(-xc) : xc;
    ay = yc[W-1] ? W'(-yc) : yc;
    onehot = (bus.select != 4'd0) && ((bus.select & (bus.select - 4'd1)) == 4'd0);
    is_tan = onehot && bus.select[SEL_TAN];
    tan_neg = xc[W-1] ^ yc[W-1];
    tan_sat = (xc == '0) || ({{FRAC{1'b0}}, ay} >= {1'b0, ax, {(FRAC-1){1'b0}}});
    sel_data = !onehot ? '0 : bus.select[SEL_SIN] ? yc : bus.select[SEL_COS] ? xc :
               bus.select[SEL_ATAN] ? bus.angle_in : (tan_neg ? Q_MIN_SAT : Q_MAX);
    accept = (state == S_HOLD) && bus.out_valid && bus.out_ready;
    capture = bus.core_valid && ((state == S_IDLE) || accept);
  end
  cordic_seq_div u_div (
    .clk(clk),
    .rst(rst),
    .start(capture && is_tan),
    .dividend({ay, {FRAC{1'b0}}}),
    .divisor(ax),
    .done(div_done),
    .quotient(q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      bus.out_valid <= 1'b0;
      bus.out_data <= '0;
      bus.err <= 1'b0;
      bus.overrun <= 1'b0;
      data_p <= '0;
      err_p <= 1'b0;
      tan_r <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      if (bus.core_valid && !capture) bus.overrun <= 1'b1;
      if (accept) bus.out_valid <= 1'b0;
      if (capture) begin
        data_p <= sel_data;
        err_p <= !onehot || (is_tan && tan_sat);
        tan_r <= is_tan;
        neg_r <= tan_neg;
        state <= is_tan ? S_DIV : S_FMT;
      end else if (state == S_DIV && div_done) begin
        state <= S_FMT;
      end else if (state == S_FMT) begin
        bus.out_data <= (tan_r && !err_p) ? (neg_r ? W'(-q) : q) : data_p;
        bus.err <= err_p;
        bus.out_valid <= 1'b1;
        state <= S_HOLD;
      end else if (accept) begin
        state <= S_IDLE;
      end
    end
  end
  assign bus.busy = state != S_IDLE;
endmodule

// File: tb/tb_cordic_result_unit.sv
// tb_cordic_result_unit: directed and randomized checks of cordic_result_unit against an integer reference model
module tb_cordic_result_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  cordic_result_unit_if bus();
  cordic_result_unit dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic [15:0] a,
                                input logic [1:0] inf, input logic [3:0] sel,
                                output logic [15:0] d, output logic e, output int lat);
    int xi, yi, q;
    logic neg;
    xi = int'($signed(x));
    yi = int'($signed(y));
    if (inf[0]) xi = (xi == -32768) ? 32767 : -xi;
    if (inf[1]) yi = (yi == -32768) ? 32767 : -yi;
    neg = (xi < 0) != (yi < 0);
    lat = 2;
    e = 1'b0;
    d = 16'h0000;
    if ($countones(sel) != 1) e = 1'b1;
    else if (sel == 4'b0001) d = 16'(yi);
    else if (sel == 4'b0010) d = 16'(xi);
    else if (sel == 4'b1000) d = a;
    else begin
      lat = 18;
      if (xi == 0 || iabs(yi) >= iabs(xi) * 128) begin
        e = 1'b1;
        d = neg ? 16'h8001 : 16'h7FFF;
      end else begin
        q = iabs(yi) * 256 / iabs(xi);
        d = 16'(neg ? -q : q);
      end
    end
  endfunction

  task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic [15:0] a,
                        input logic [1:0] inf, input logic [3:0] sel);
    logic [15:0] d;
    logic e;
    int lat, n;
    model(x, y, a, inf, sel, d, e, lat);
    bus.x_in = x;
    bus.y_in = y;
    bus.angle_in = a;
    bus.infor = inf;
    bus.select = sel;
    bus.core_valid = 1'b1;
    tick;
    bus.core_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick;
      n++;
    end
    chk({tag, " latency"}, n, lat);
    chk({tag, " data"}, bus.out_data, d);
    chk({tag, " err"}, bus.err, e);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk({tag, " valid_drop"}, bus.out_valid, 0);
    chk({tag, " idle"}, bus.busy, 0);
  endtask

  initial begin
    int k;
    logic [3:0] s;
    bus.core_valid = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.angle_in = '0;
    bus.infor = '0;
    bus.select = '0;
    bus.out_ready = 1'b0;
    tick;
    tick;
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_data", bus.out_data, 0);
    chk("rst err", bus.err, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst overrun", bus.overrun, 0);
    rst = 1'b0;
    tick;
    run_op("sin", 16'h0000, 16'h0080, 16'h0000, 2'b00, 4'b0001);
    run_op("cos_quad", 16'h00DE, 16'h0000, 16'h0000, 2'b01, 4'b0010);
    run_op("cos_sat", 16'h8000, 16'h0000, 16'h0000, 2'b01, 4'b0010);
    run_op("tan_pos", 16'h00B5, 16'h00B5, 16'h0000, 2'b00, 4'b0100);
    run_op("tan_neg", 16'h00B5, 16'hFF4B, 16'h0000, 2'b00, 4'b0100);
    run_op("tan_x0", 16'h0000, 16'h00B5, 16'h0000, 2'b00, 4'b0100);
    run_op("tan_ovf_neg", 16'h0001, 16'hC000, 16'h0000, 2'b00, 4'b0100);
    run_op("atan", 16'h0011, 16'h0022, 16'h1234, 2'b11, 4'b1000);
    run_op("bad_sel", 16'h0005, 16'h0006, 16'h0007, 2'b00, 4'b0011);
    run_op("bad_sel0", 16'h0005, 16'h0006, 16'h0007, 2'b00, 4'b0000);
    bus.y_in = 16'h1111;
    bus.infor = 2'b00;
    bus.select = 4'b0001;
    bus.core_valid = 1'b1;
    tick;
    bus.core_valid = 1'b0;
    tick;
    chk("bp valid", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("bp stable", bus.out_data, 16'h1111);
      chk("bp held", bus.out_valid, 1);
    end
    bus.x_in = 16'h0200;
    bus.select = 4'b0010;
    bus.out_ready = 1'b1;
    bus.core_valid = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    bus.core_valid = 1'b0;
    chk("b2b busy", bus.busy, 1);
    chk("b2b overrun", bus.overrun, 0);
    chk("b2b gap", bus.out_valid, 0);
    tick;
    chk("b2b valid", bus.out_valid, 1);
    chk("b2b data", bus.out_data, 16'h0200);
    bus.x_in = 16'h0300;
    bus.core_valid = 1'b1;
    tick;
    bus.core_valid = 1'b0;
    chk("ovr flag", bus.overrun, 1);
    chk("ovr data", bus.out_data, 16'h0200);
    chk("ovr valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    tick;
    bus.out_ready = 1'b0;
    chk("ovr drop", bus.out_valid, 0);
    chk("ovr sticky", bus.overrun, 1);
    bus.x_in = 16'h00B5;
    bus.y_in = 16'h00B5;
    bus.select = 4'b0100;
    bus.core_valid = 1'b1;
    tick;
    bus.core_valid = 1'b0;
    repeat (7) tick;
    chk("div busy", bus.busy, 1);
    chk("div no_valid", bus.out_valid, 0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort busy", bus.busy, 0);
    chk("abort valid", bus.out_valid, 0);
    chk("abort data", bus.out_data, 0);
    chk("abort overrun", bus.overrun, 0);
    run_op("tan_after_rst", 16'h0100, 16'h0080, 16'h0000, 2'b10, 4'b0100);
    for (int i = 0; i < 30; i++) begin
      k = int'($urandom_range(0, 5));
      s = (k < 4) ? 4'(1 << k) : (k == 4) ? 4'b0100 : 4'($urandom);
      run_op("rand", 16'($urandom), 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)), s);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cordic_result_unit.md
# cordic_result_unit

Output stage of the CORDIC coprocessor. It captures the raw x/y/angle vectors from the iteration core when a computation finishes, applies the quadrant correction produced by the angle-folding front end, and forms the result selected by software: sin, cos, tan or arctan. tan requires y/x, which the block computes with a sequential restoring divider. The formatted Q7.8 result is held behind a valid/ready handshake until the consumer (register file or bus slave) accepts it.

## Interface
- `W`, 16: data width of all vectors.
- `FRAC`, 8: fractional bits of the Q7.8 format.
- `clk` in 1: single clock; everything samples on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `core_valid` in 1: one-cycle pulse from the iteration core; `x_in`, `y_in`, `angle_in` and `infor` are valid in that cycle.
- `x_in` in 16: signed Q7.8 cos-axis result.
- `y_in` in 16: signed Q7.8 sin-axis result.
- `angle_in` in 16: signed Q7.8 accumulated angle in degrees; this is the arctan result.
- `infor` in 2: quadrant info. Bit 0 negates x; bit 1 negates y.
- `select` in 4: one-hot function select. Bit 0 = sin, bit 1 = cos, bit 2 = tan, bit 3 = arctan. Sampled together with `core_valid`.
- `out_ready` in 1: consumer accepts the result.
- `out_valid` out 1: result available.
- `out_data` out 16: signed Q7.8 result.
- `err` out 1: qualifies `out_data`. Set on tan overflow, divide-by-zero, or an invalid select.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky flag. Set when `core_valid` is dropped; cleared only by `rst`.

## Operation
- FSM states and transitions:
  - IDLE: on `core_valid`, latch the inputs and go to FMT, or to DIV when `select` = tan.
  - DIV: run 16 iterations, then go to FMT.
  - FMT: register the result, then go to HOLD.
  - HOLD: wait for `out_valid && out_ready`.
- Quadrant correction is applied on capture:
  - `xc = infor[0] ? -x_in : x_in`.
  - `yc = infor[1] ? -y_in : y_in`.
  - Negating 0x8000 saturates to 0x7FFF.
- sin result = `yc`; cos result = `xc`; arctan result = `angle_in`, passed unchanged.
- tan result = `yc/xc`, with `|yc|` and `|xc|` as unsigned magnitudes:
  - If `xc` = 0, or `|yc|` >= `|xc|`<<7: saturate to 0x7FFF (positive) or 0x8001 (negative) and set `err`. The divider runs its 16 cycles anyway so latency stays fixed.
  - Otherwise: restoring division of `|yc|`<<8 by `|xc|`, one quotient bit per cycle, MSB first.
  - Sign = `sign(yc) XOR sign(xc)`. The magnitude is negated in FMT.
- If `select` is not one-hot: `out_data` = 0x0000 and `err` = 1.
- `core_valid` arriving while `busy` and not in the accept cycle (below) is dropped and sets `overrun`.
- HOLD with `out_valid && out_ready` and `core_valid` in the same cycle:
  - The transfer completes and the new vector is captured.
  - FSM goes directly to FMT or DIV.
  - `overrun` is not set.

## Timing
- Reset values: `out_valid`=0, `out_data`=0x0000, `err`=0, `busy`=0, `overrun`=0, FSM = IDLE, divider registers cleared.
- `rst` asserted mid-DIV or in HOLD aborts the operation. Next cycle: all outputs are at reset values and the held result is lost.
- Latency, measured as edges from the `core_valid` cycle to the first `out_valid` cycle:
  - sin, cos, arctan: 2.
  - tan: 18 (capture, 16 DIV, FMT).
- `out_data` and `err` are stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` drops the cycle after a transfer, unless a back-to-back capture is in progress.
- `busy` is high from the cycle after capture through the transfer cycle. Sustained throughput:
  - Non-tan: one result every 2 cycles.
  - tan: one result every 18 cycles.

## Structure
- Shared package `cordic_pkg` holds:
  - Function-select bit indices (`SEL_SIN`=0, `SEL_COS`=1, `SEL_TAN`=2, `SEL_ATAN`=3).
  - `Q_MAX`=0x7FFF, `Q_MIN_SAT`=0x8001, `FRAC`=8.
  - FSM state enum.
  - Saturating-negate function.
- Sub-module `cordic_seq_div`: a 16-cycle unsigned restoring divider.
  - Inputs: `start`, 24-bit dividend, 16-bit divisor.
  - Outputs: `done`, 16-bit quotient.
  - It is reset by the same `rst`.

## Test plan
- sin: `y_in`=0x0080, `infor`=0, `select`=0001 -> `out_data`=0x0080 and `err`=0, with `out_valid` 2 cycles after `core_valid`.
- cos with quadrant fix: `x_in`=0x00DE, `infor`=01, `select`=0010 -> `out_data`=0xFF22. Also `x_in`=0x8000 with `infor`=01 -> 0x7FFF.
- tan:
  - `x_in`=`y_in`=0x00B5, `select`=0100 -> 0x0100, `out_valid` 18 cycles after capture.
  - `x_in`=0x00B5 with `y_in`=0xFF4B -> 0xFF00.
  - `x_in`=0 -> 0x7FFF with `err`=1.
- Backpressure and overrun: hold `out_ready`=0 for 5 cycles -> `out_data` is stable throughout. A second `core_valid` during HOLD -> `overrun`=1 and the first result is unchanged. `core_valid` in the accept cycle -> captured, with `overrun` unchanged.
- Reset and invalid select:
  - `rst` at DIV cycle 8 -> next cycle `busy`=0, `out_valid`=0, `out_data`=0.
  - `select`=0011 -> `out_data`=0x0000 with `err`=1.
